activation_unit: RTL

Multi-lane activation stage placed between the accumulator output and the result writeback path. It applies a per-frame selectable activation function (bypass, ReLU, clipped ReLU, leaky ReLU) to NUM_LANES signed lanes per beat. Input and output use valid/ready handshakes, so writeback backpressure is absorbed without dropping beats. Address and last are carried alongside each beat unchanged.

---
 rtl/act_pkg.sv | 18 +
 rtl/act_lane.sv | 34 +++
 rtl/activation_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/act_pkg.sv
// Shared types for the activation stage: activation modes, frame FSM states, shift width.
package act_pkg;

  typedef enum logic [1:0] {
    BYPASS    = 2'd0,
    RELU      = 2'd1,
    RELU_CLIP = 2'd2,
    LEAKY     = 2'd3
  } act_mode_e;

  localparam int ACT_SHIFT_WIDTH = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } act_state_e;

endpackage

// File: rtl/act_lane.sv
// Single-lane activation function, purely combinational.
module act_lane
  import act_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic signed [DATA_WIDTH-1:0]      x,
    input  act_mode_e                         mode,
    input  logic signed [DATA_WIDTH-1:0]      clip,
    input  logic        [ACT_SHIFT_WIDTH-1:0] shift,
    output logic signed [DATA_WIDTH-1:0]      y
);

    logic signed [DATA_WIDTH-1:0] ceiling;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        ceiling = clip[DATA_WIDTH-1] ? '0 : clip;
        y       = x;
        case (mode)
            BYPASS:    y = x;
            RELU:      y = x[DATA_WIDTH-1] ? '0 : x;
            RELU_CLIP: begin
                if (x[DATA_WIDTH-1])  y = '0;
                else if (x > ceiling) y = ceiling;
                else                  y = x;
            end
            // Arithmetic shift of a negative value rounds toward -inf, so -1 stays -1.
            LEAKY:     y = x[DATA_WIDTH-1] ? (x >>> shift) : x;
            default:   y = x;
        endcase
    end

endmodule

// File: rtl/activation_unit.sv
// Multi-lane activation stage with a 2-entry output skid buffer and per-frame configuration latch.
// Optional macro ACT_ZERO_COUNT_EN adds a per-frame zero-lane counter.
module activation_unit
  import act_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_LANES     = 4,
`ifdef ACT_ZERO_COUNT_EN
    parameter int ZCNT_WIDTH    = 16,
`endif
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [1:0]                        cfg_mode_i,
    input  logic [DATA_WIDTH-1:0]             cfg_clip_i,
    input  logic [ACT_SHIFT_WIDTH-1:0]        cfg_shift_i,
    input  logic                              acc_valid_i,
    output logic                              acc_ready_o,
    input  logic                              acc_last_i,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]   acc_result_i,
    input  logic [ADDRESS_WIDTH-1:0]          acc_result_address_i,
    output logic                              act_valid_o,
    input  logic                              act_ready_i,
    output logic                              act_last_o,
    output logic [NUM_LANES*DATA_WIDTH-1:0]   act_result_o,
    output logic [ADDRESS_WIDTH-1:0]          act_result_address_o,
    output logic                              busy_o
`ifdef ACT_ZERO_COUNT_EN
    ,
    output logic [ZCNT_WIDTH-1:0]             act_zero_cnt_o,
    output logic                              act_zero_cnt_valid_o
`endif
);

    localparam int BEAT_W = NUM_LANES * DATA_WIDTH;

    typedef struct packed {
        logic                     last;
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [BEAT_W-1:0]        data;
    } beat_t;

    act_state_e                 state_q, state_d;
    act_mode_e                  mode_q, mode_eff;
    logic [DATA_WIDTH-1:0]      clip_q, clip_eff;
    logic [ACT_SHIFT_WIDTH-1:0] shift_q, shift_eff;

    beat_t             a_q, b_q, in_beat;
    logic              a_valid_q, b_valid_q, b_valid_d, ready_q;
    logic              in_fire, out_fire;
    logic [BEAT_W-1:0] lane_y;

    assign in_fire  = acc_valid_i && ready_q;
    assign out_fire = a_valid_q && act_ready_i;

    // The first beat of a frame is processed with the live cfg; later beats use the latched copy.
    assign mode_eff  = (state_q == IDLE) ? act_mode_e'(cfg_mode_i) : mode_q;
    assign clip_eff  = (state_q == IDLE) ? cfg_clip_i  : clip_q;
    assign shift_eff = (state_q == IDLE) ? cfg_shift_i : shift_q;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        act_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .x     (acc_result_i[k*DATA_WIDTH +: DATA_WIDTH]),
            .mode  (mode_eff),
            .clip  (clip_eff),
            .shift (shift_eff),
            .y     (lane_y[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign in_beat = '{last: acc_last_i, addr: acc_result_address_i, data: lane_y};

    // Frame FSM: state register, next-state logic, outputs.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_fire && !acc_last_i) state_d = FRAME;
            FRAME:   if (in_fire &&  acc_last_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb busy_o = (state_q == FRAME);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q  <= BYPASS;
            clip_q  <= '0;
            shift_q <= '0;
        end else if (in_fire && state_q == IDLE) begin
            mode_q  <= act_mode_e'(cfg_mode_i);
            clip_q  <= cfg_clip_i;
            shift_q <= cfg_shift_i;
        end
    end

    // Skid entry B only fills when A is held by backpressure; ready is simply "B will be empty".
    assign b_valid_d = b_valid_q ? !out_fire : (in_fire && a_valid_q && !out_fire);

    // NOTE: both buffer entries are reset, not just their valid bits, so outputs read 0 out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q       <= '0;
            b_q       <= '0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            ready_q   <= !b_valid_d;
            b_valid_q <= b_valid_d;
            if (b_valid_q) begin
                if (out_fire) a_q <= b_q;
            end else if (in_fire) begin
                if (a_valid_q && !out_fire) begin
                    b_q <= in_beat;
                end else begin
                    a_q       <= in_beat;
                    a_valid_q <= 1'b1;
                end
            end else if (out_fire) begin
                a_valid_q <= 1'b0;
            end
        end
    end

    assign acc_ready_o          = ready_q;
    assign act_valid_o          = a_valid_q;
    assign act_last_o           = a_q.last;
    assign act_result_o         = a_q.data;
    assign act_result_address_o = a_q.addr;

`ifdef ACT_ZERO_COUNT_EN
    localparam int ZEROS_W = $clog2(NUM_LANES + 1);

    logic [ZCNT_WIDTH-1:0] zcnt_q, zcnt_sat;
    logic [ZCNT_WIDTH:0]   zcnt_sum;
    logic [ZEROS_W-1:0]    zeros;

    always_comb begin
        zeros = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (a_q.data[k*DATA_WIDTH +: DATA_WIDTH] == '0) zeros = zeros + ZEROS_W'(1);
        end
        zcnt_sum = {1'b0, zcnt_q} + (ZCNT_WIDTH + 1)'(zeros);
        zcnt_sat = zcnt_sum[ZCNT_WIDTH] ? '1 : zcnt_sum[ZCNT_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            zcnt_q               <= '0;
            act_zero_cnt_o       <= '0;
            act_zero_cnt_valid_o <= 1'b0;
        end else begin
            act_zero_cnt_valid_o <= 1'b0;
            if (out_fire) begin
                if (a_q.last) begin
                    act_zero_cnt_o       <= zcnt_sat;
                    act_zero_cnt_valid_o <= 1'b1;
                    zcnt_q               <= '0;
                end else begin
                    zcnt_q <= zcnt_sat;
                end
            end
        end
    end
`endif

endmodule
